// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the staged ALU control: ALUOp classes, R-type funct
// codes, ALU operation codes, HI/LO unit op codes and the sequencer state.
package alu_ctrl_pkg;

  localparam logic [2:0] AOP_LWSW   = 3'b000;
  localparam logic [2:0] AOP_ANDI   = 3'b001;
  localparam logic [2:0] AOP_BRANCH = 3'b010;
  localparam logic [2:0] AOP_SLTI   = 3'b011;
  localparam logic [2:0] AOP_ADDI   = 3'b100;
  localparam logic [2:0] AOP_ORI    = 3'b101;
  localparam logic [2:0] AOP_LUI    = 3'b110;
  localparam logic [2:0] AOP_RTYPE  = 3'b111;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0110;
  localparam logic [3:0] OP_SRL     = 4'b0111;
  localparam logic [3:0] OP_SLT     = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;
  localparam logic [3:0] OP_MFHI    = 4'b1010;
  localparam logic [3:0] OP_MFLO    = 4'b1011;
  localparam logic [3:0] OP_NOP     = 4'b1111;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic {IDLE, RUN} mdu_state_e;

  function automatic logic [1:0] mdu_op_of(input logic [5:0] funct);
    logic [1:0] op;
    op = MDU_MULT;
    case (funct)
      F_MULTU: op = MDU_MULTU;
      F_DIV:   op = MDU_DIV;
      F_DIVU:  op = MDU_DIVU;
      default: op = MDU_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder: operation code, shift-amount select,
// illegal-funct flag and the multiply/divide classification used by the interlock.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int OPER_W  = 4
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OPER_W-1:0]  operation,
  output logic               shamt,
  output logic               illegal,
  output logic               mdu_class,
  output logic               is_mdu_start
);

  logic [3:0] op4;

  always_comb begin
    op4          = OP_ILLEGAL;
    shamt        = 1'b0;
    illegal      = 1'b0;
    mdu_class    = 1'b0;
    is_mdu_start = 1'b0;
    case (alu_op)
      ALUOP_W'(AOP_LWSW):   op4 = OP_ADD;
      ALUOP_W'(AOP_ANDI):   op4 = OP_AND;
      ALUOP_W'(AOP_BRANCH): op4 = OP_SUB;
      ALUOP_W'(AOP_SLTI):   op4 = OP_SLT;
      ALUOP_W'(AOP_ADDI):   op4 = OP_ADD;
      ALUOP_W'(AOP_ORI):    op4 = OP_OR;
      ALUOP_W'(AOP_LUI):    op4 = OP_LUI;
      default: begin
        // R-type: the remaining ALUOp code
        case (funct)
          FUNCT_W'(F_AND): op4 = OP_AND;
          FUNCT_W'(F_OR):  op4 = OP_OR;
          FUNCT_W'(F_NOR): op4 = OP_NOR;
          FUNCT_W'(F_ADD): op4 = OP_ADD;
          FUNCT_W'(F_SUB): op4 = OP_SUB;
          FUNCT_W'(F_SLT): op4 = OP_SLT;
          FUNCT_W'(F_SLL): begin op4 = OP_SLL; shamt = 1'b1; end
          FUNCT_W'(F_SRL): begin op4 = OP_SRL; shamt = 1'b1; end
          FUNCT_W'(F_MFHI): begin op4 = OP_MFHI; mdu_class = 1'b1; end
          FUNCT_W'(F_MFLO): begin op4 = OP_MFLO; mdu_class = 1'b1; end
          FUNCT_W'(F_MULT), FUNCT_W'(F_MULTU),
          FUNCT_W'(F_DIV),  FUNCT_W'(F_DIVU): begin
            op4          = OP_NOP;
            mdu_class    = 1'b1;
            is_mdu_start = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign operation = OPER_W'(op4);

endmodule

// File: rtl/alu_control_staged.sv
// Registered ALU control at the ID/EX boundary with valid/stall/flush handshake,
// multiply/divide run sequencer and MFHI/MFLO interlock against the HI/LO unit.
module alu_control_staged
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int FUNCT_W     = 6,
  parameter int OPER_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] ALUFunction,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [OPER_W-1:0]  ALUOperation,
  output logic               Shamt,
  output logic               illegal_o,
  output logic               mdu_start_o,
  output logic [1:0]         mdu_op_o,
  output logic               hilo_we_o,
  output logic               mdu_busy_o
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [OPER_W-1:0] dec_op;
  logic              dec_shamt, dec_illegal, dec_mdu_class, dec_mdu_start;
  logic [1:0]        dec_mdu_op;
  logic              accept, launch;

  logic              valid_q, valid_d;
  logic [OPER_W-1:0] op_q, op_d;
  logic              shamt_q, shamt_d;
  logic              illegal_q, illegal_d;
  logic              start_q, start_d;
  logic [1:0]        mdu_op_q, mdu_op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_state_e        state_q, state_d;

  alu_ctrl_decode #(
    .ALUOP_W(ALUOP_W),
    .FUNCT_W(FUNCT_W),
    .OPER_W (OPER_W)
  ) u_decode (
    .alu_op      (ALUOp),
    .funct       (ALUFunction),
    .operation   (dec_op),
    .shamt       (dec_shamt),
    .illegal     (dec_illegal),
    .mdu_class   (dec_mdu_class),
    .is_mdu_start(dec_mdu_start)
  );

  assign dec_mdu_op = mdu_op_of(6'(ALUFunction));
  assign mdu_busy_o = (state_q == RUN);
  // The hilo_we_o cycle still counts as busy, so MFHI/MFLO there is refused.
  assign ready_o    = ~stall_i & ~(dec_mdu_class & mdu_busy_o);
  assign accept     = valid_i & ready_o;
  assign launch     = accept & dec_mdu_start & ~flush_i & (state_q == IDLE);

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    shamt_d   = shamt_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (accept) begin
      valid_d   = 1'b1;
      op_d      = dec_op;
      shamt_d   = dec_shamt;
      illegal_d = dec_illegal;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Run sequencer is free-running once launched; stall and flush do not touch it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_op_d = mdu_op_q;
    start_d  = 1'b0;
    case (state_q)
      IDLE: if (launch) begin
        state_d  = RUN;
        start_d  = 1'b1;
        mdu_op_d = dec_mdu_op;
        cnt_d    = dec_mdu_op[1] ? DIV_LOAD : MULT_LOAD;
      end
      RUN: if (cnt_q == '0) state_d = IDLE;
           else             cnt_d   = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      op_q      <= OPER_W'(OP_ILLEGAL);
      shamt_q   <= 1'b0;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      mdu_op_q  <= MDU_MULT;
      cnt_q     <= '0;
      state_q   <= IDLE;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      shamt_q   <= shamt_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      mdu_op_q  <= mdu_op_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign valid_o      = valid_q;
  assign ALUOperation = op_q;
  assign Shamt        = shamt_q;
  assign illegal_o    = illegal_q;
  assign mdu_start_o  = start_q;
  assign mdu_op_o     = mdu_op_q;
  assign hilo_we_o    = (state_q == RUN) && (cnt_q == '0);

endmodule

// File: doc/alu_control_staged.md
Name: alu_control_staged

Overview:
- Registered, parametrised successor to the combinational ALU control decoder for the pipelined MIPS core; sits at the ID/EX boundary.
- Decodes ALUOp plus the R-type function field into an ALU operation code and a shamt-select, and registers the result with a valid/stall/flush handshake.
- Sequences multi-cycle multiply/divide (MULT/MULTU/DIV/DIVU) on an external HI/LO unit.
- Interlocks MFHI/MFLO and back-to-back multiply/divide ops against an in-flight operation.

Parameters:
- ALUOP_W, 3, width of ALUOp from main control; all 8 codes are decoded.
- FUNCT_W, 6, width of the function field.
- OPER_W, 4, width of ALUOperation; must be ≥4; codes are zero-extended.
- MULT_CYCLES, 4, multiply run length in cycles; must be ≥2.
- DIV_CYCLES, 16, divide run length in cycles; must be ≥2.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  decode slot holds an instruction.
- ALUOp  in  ALUOP_W  class code from main control.
- ALUFunction  in  FUNCT_W  instruction funct field.
- stall_i  in  1  downstream hold.
- flush_i  in  1  kill the output slot.
- ready_o  out  1  instruction accepted this cycle when valid_i=1.
- valid_o  out  1  output slot valid.
- ALUOperation  out  OPER_W  registered ALU operation code.
- Shamt  out  1  registered shift-amount select.
- illegal_o  out  1  registered flag: unknown R-type funct.
- mdu_start_o  out  1  one-cycle start pulse to HI/LO unit.
- mdu_op_o  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held for the whole run.
- hilo_we_o  out  1  HI/LO write strobe, asserted in the last run cycle.
- mdu_busy_o  out  1  state ≠ IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - valid_o, Shamt, illegal_o, mdu_start_o, hilo_we_o, mdu_busy_o = 0.
  - ALUOperation = 4'b1001; mdu_op_o = 00; counter = 0; state = IDLE.
  - Reset asserted mid-run aborts the run with no hilo_we_o.
- ALUOp decode:
  - 000 → ADD 0011 (LW/SW).
  - 001 → AND 0000 (ANDI).
  - 010 → SUB 0100 (BEQ/BNE).
  - 011 → SLT 1000 (SLTI).
  - 100 → ADD 0011 (ADDI).
  - 101 → OR 0001 (ORI).
  - 110 → LUI 0101.
  - 111 → R-type; decode funct as below.
- R-type funct decode:
  - 100100 → AND 0000; 100101 → OR 0001; 100111 → NOR 0010.
  - 100000 → ADD 0011; 100010 → SUB 0100; 101010 → SLT 1000.
  - 000000 → SLL 0110 with Shamt=1; 000010 → SRL 0111 with Shamt=1.
  - 010000 → MFHI 1010; 010010 → MFLO 1011.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU → NOP 1111, valid_o=1.
  - Any other funct → 1001 with illegal_o=1.
- Accept condition: valid_i & ready_o.
- ready_o = ~stall_i & ~(mdu_class & mdu_busy_o).
  - mdu_class is true for MULT/MULTU/DIV/DIVU/MFHI/MFLO.
  - Non-MDU instructions pass freely during a run.
- Latency: 1 cycle. On an accept edge, the output registers load the decoded values and valid_o=1.
- No accept and no stall: valid_o ← 0; other outputs hold their last value.
- stall_i=1: all output registers hold.
- flush_i=1: valid_o ← 0 and illegal_o ← 0 next edge.
  - Overrides stall_i and accept.
  - Does not abort an in-flight MDU run.
- FSM IDLE:
  - Accepting a MULT*/DIV* (and not flushed) sets mdu_start_o=1 for the next cycle only.
  - Latches mdu_op_o.
  - Loads counter with MULT_CYCLES−1 or DIV_CYCLES−1.
  - Goes to RUN.
- FSM RUN:
  - Counter decrements each cycle, independent of stall_i.
  - When counter=0: hilo_we_o=1 for that cycle, then IDLE.
  - Total mdu_busy_o high time = MULT_CYCLES or DIV_CYCLES.
- Hazard boundary: an MFHI presented in the hilo_we_o cycle is refused (still busy) and accepted on the following cycle.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALUOp codes, funct codes, ALUOperation codes (including ILLEGAL 1001, NOP 1111, MFHI 1010, MFLO 1011).
  - mdu_op encodings.
  - FSM state typedef {IDLE, RUN}.
- One combinational sub-module, alu_ctrl_decode: ALUOp and funct in; operation, Shamt, illegal, mdu_class and is_mdu_start out.
- Top level holds the registers, handshake and FSM.

Test Plan:
- Reset then ALUOp=111 funct=000010, valid_i=1 → next cycle ALUOperation=0111, Shamt=1, valid_o=1, illegal_o=0.
- ALUOp=111 funct=111111 → ALUOperation=1001, illegal_o=1; a flush_i in the same cycle → valid_o=0, illegal_o=0.
- MULT accepted at cycle t:
  - mdu_start_o=1 at t+1.
  - mdu_busy_o high t+1..t+4.
  - hilo_we_o=1 only at t+4.
  - An ADD issued at t+2 is accepted with ALUOperation=0011.
- DIV followed immediately by MFLO:
  - ready_o=0 for MFLO through the hilo_we_o cycle (16 cycles).
  - MFLO accepted on the next cycle; ALUOperation=1011 one cycle later.
- stall_i held 3 cycles with valid_o=1 (SUB) → outputs stable, ready_o=0; release → next instruction loads.
- reset pulsed low mid-DIV run (counter=7) → immediate IDLE, mdu_busy_o=0, no hilo_we_o pulse ever.
